// File: rtl/vga_sync_gen.sv
// vga_sync_gen: XGA raster timing source for the VGA text console.
// Free-running pixel/line counters delivered in split form
// (x = x_hi*32 + x_lo, y = y_hi*48 + y_lo) together with registered
// hsync/vsync/blank and a sticky frame interrupt.
// Optional feature macro: VGA_SYNC_LINE_IRQ_EN adds a raster-split interrupt
// that also sets at (x=0, y=IRQ_LINE).
module vga_sync_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_TOTAL  = 1344,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_TOTAL  = 806,
    parameter int IRQ_LINE = 384
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cli,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       interrupt,
    output logic [4:0] x_lo,
    output logic [5:0] x_hi,
    output logic [5:0] y_lo,
    output logic [4:0] y_hi
);

    // x is a plain concatenation of {x_hi, x_lo} because the low field is 32 wide.
    localparam logic [5:0]  X_HI_LAST = 6'((H_TOTAL - 1) / 32);
    localparam logic [4:0]  Y_HI_LAST = 5'((V_TOTAL - 1) / 48);
    localparam logic [5:0]  Y_LO_LAST = 6'((V_TOTAL - 1) % 48);
    localparam logic [10:0] HA_END    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam int          VS_START  = V_ACTIVE + V_FP;
    localparam int          VS_END    = V_ACTIVE + V_FP + V_SYNC;

    // y is compared field by field so that no multiply by 48 is needed.
    function automatic logic y_at_or_past(input logic [4:0] hi, input logic [5:0] lo,
                                          input int line);
        logic [4:0] l_hi;
        logic [5:0] l_lo;
        l_hi = 5'(line / 48);
        l_lo = 6'(line % 48);
        return (hi > l_hi) || ((hi == l_hi) && (lo >= l_lo));
    endfunction

    function automatic logic y_is(input logic [4:0] hi, input logic [5:0] lo,
                                  input int line);
        return (hi == 5'(line / 48)) && (lo == 6'(line % 48));
    endfunction

    logic [4:0]  x_lo_reg, x_lo_next;
    logic [5:0]  x_hi_reg, x_hi_next;
    logic [5:0]  y_lo_reg, y_lo_next;
    logic [4:0]  y_hi_reg, y_hi_next;
    logic        hsync_reg, hsync_next;
    logic        vsync_reg, vsync_next;
    logic        blank_reg, blank_next;
    logic        irq_reg, irq_next;
    logic        line_end, frame_end, irq_set;
    logic [10:0] x_next;

    // Next raster position plus the sync/blank/interrupt values that describe it,
    // so the registered outputs line up with the registered coordinates.
    always_comb begin
        line_end  = (x_hi_reg == X_HI_LAST) && (x_lo_reg == 5'd31);
        frame_end = (y_hi_reg == Y_HI_LAST) && (y_lo_reg == Y_LO_LAST);

        x_lo_next = x_lo_reg + 5'd1;
        x_hi_next = x_hi_reg;
        y_lo_next = y_lo_reg;
        y_hi_next = y_hi_reg;

        if (line_end) begin
            x_hi_next = 6'd0;
            if (frame_end) begin
                y_lo_next = 6'd0;
                y_hi_next = 5'd0;
            end else if (y_lo_reg == 6'd47) begin
                y_lo_next = 6'd0;
                y_hi_next = y_hi_reg + 5'd1;
            end else begin
                y_lo_next = y_lo_reg + 6'd1;
            end
        end else if (x_lo_reg == 5'd31) begin
            x_hi_next = x_hi_reg + 6'd1;
        end

        x_next     = {x_hi_next, x_lo_next};
        hsync_next = !((x_next >= HS_START) && (x_next < HS_END));
        vsync_next = !(y_at_or_past(y_hi_next, y_lo_next, VS_START) &&
                       !y_at_or_past(y_hi_next, y_lo_next, VS_END));
        blank_next = (x_next >= HA_END) || y_at_or_past(y_hi_next, y_lo_next, V_ACTIVE);

`ifdef VGA_SYNC_LINE_IRQ_EN
        irq_set = (x_next == 11'd0) &&
                  (y_is(y_hi_next, y_lo_next, V_ACTIVE) || y_is(y_hi_next, y_lo_next, IRQ_LINE));
`else
        irq_set = (x_next == 11'd0) && y_is(y_hi_next, y_lo_next, V_ACTIVE);
`endif
        // A set in the same cycle as cli wins.
        irq_next = irq_set || (irq_reg && !cli);
    end

    // Raster state and output registers; reset restarts cleanly at (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            x_lo_reg  <= 5'd0;
            x_hi_reg  <= 6'd0;
            y_lo_reg  <= 6'd0;
            y_hi_reg  <= 5'd0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            blank_reg <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            x_lo_reg  <= x_lo_next;
            x_hi_reg  <= x_hi_next;
            y_lo_reg  <= y_lo_next;
            y_hi_reg  <= y_hi_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            blank_reg <= blank_next;
            irq_reg   <= irq_next;
        end
    end

    assign x_lo      = x_lo_reg;
    assign x_hi      = x_hi_reg;
    assign y_lo      = y_lo_reg;
    assign y_hi      = y_hi_reg;
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign blank     = blank_reg;
    assign interrupt = irq_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. One instance uses the XGA timing for the line
// test; a second instance uses a shrunken raster (64x60, same 32/48 field
// split) so whole frames and the interrupt lines are reachable quickly.
// Honours VGA_SYNC_LINE_IRQ_EN when choosing the raster-split expectation.
module tb_vga_sync_gen;

    // Shrunken raster for frame-level checks.
    localparam int S_HA = 40, S_HFP = 4, S_HS = 8, S_HT = 64;
    localparam int S_VA = 50, S_VFP = 2, S_VS = 3, S_VT = 60, S_IRQ = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cli = 1'b0;

    logic       d_hsync, d_vsync, d_blank, d_int;
    logic [4:0] d_x_lo;
    logic [5:0] d_x_hi;
    logic [5:0] d_y_lo;
    logic [4:0] d_y_hi;

    logic       s_hsync, s_vsync, s_blank, s_int;
    logic [4:0] s_x_lo;
    logic [5:0] s_x_hi;
    logic [5:0] s_y_lo;
    logic [4:0] s_y_hi;

    int checks = 0;
    int errors = 0;

    // Reference raster positions for both instances.
    int dx = 0, dy = 0;
    int sx = 0, sy = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut_xga (
        .clk(clk), .rst(rst), .cli(cli),
        .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank), .interrupt(d_int),
        .x_lo(d_x_lo), .x_hi(d_x_hi), .y_lo(d_y_lo), .y_hi(d_y_hi)
    );

    vga_sync_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_TOTAL(S_HT),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_TOTAL(S_VT),
        .IRQ_LINE(S_IRQ)
    ) dut_small (
        .clk(clk), .rst(rst), .cli(cli),
        .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank), .interrupt(s_int),
        .x_lo(s_x_lo), .x_hi(s_x_hi), .y_lo(s_y_lo), .y_hi(s_y_hi)
    );

    // One clock; outputs are sampled 1 time unit after the edge and the
    // reference positions advance to match.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            dx = 0; dy = 0; sx = 0; sy = 0;
        end else begin
            dx = dx + 1;
            if (dx == 1344) begin dx = 0; dy = (dy + 1) % 806; end
            sx = sx + 1;
            if (sx == S_HT) begin sx = 0; sy = (sy + 1) % S_VT; end
        end
    endtask

    // Advance the small raster to (tx,ty), bounded.
    task automatic run_to(input int tx, input int ty);
        int n;
        n = 0;
        while (!(sx == tx && sy == ty) && n < 20000) begin
            tick();
            n++;
        end
        if (!(sx == tx && sy == ty)) begin
            checks++; errors++;
            $display("FAIL run_to timeout: at (%0d,%0d) wanted (%0d,%0d)", sx, sy, tx, ty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cli = 1'b0;
        tick(); tick();
        checks++;
        if ({d_x_hi, d_x_lo, d_y_hi, d_y_lo} !== 22'd0) begin
            errors++; $display("FAIL reset_xga_coord: got %h want 0", {d_x_hi, d_x_lo, d_y_hi, d_y_lo});
        end
        checks++;
        if ({d_hsync, d_vsync, d_blank, d_int} !== 4'b1100) begin
            errors++; $display("FAIL reset_xga_flags: got %b want 1100", {d_hsync, d_vsync, d_blank, d_int});
        end
        checks++;
        if ({s_x_hi, s_x_lo, s_y_hi, s_y_lo} !== 22'd0) begin
            errors++; $display("FAIL reset_small_coord: got %h want 0", {s_x_hi, s_x_lo, s_y_hi, s_y_lo});
        end
        checks++;
        if ({s_hsync, s_vsync, s_blank, s_int} !== 4'b1100) begin
            errors++; $display("FAIL reset_small_flags: got %b want 1100", {s_hsync, s_vsync, s_blank, s_int});
        end
        rst = 1'b0;
        $display("reset: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Full XGA line: hsync low for 1048..1183, blank from 1024, wrap at 1344.
    task automatic test_line();
        logic [10:0] exp_x;
        logic        exp_hs, exp_bl;
        for (int i = 0; i <= 1344; i++) begin
            exp_x  = 11'(i % 1344);
            exp_hs = !((i % 1344) >= 1048 && (i % 1344) < 1184);
            exp_bl = (i % 1344) >= 1024;
            checks++;
            if ({d_x_hi, d_x_lo} !== exp_x) begin
                errors++; $display("FAIL line_x cyc %0d: got %0d want %0d", i, {d_x_hi, d_x_lo}, exp_x);
            end
            checks++;
            if ({d_hsync, d_blank} !== {exp_hs, exp_bl}) begin
                errors++; $display("FAIL line_hs_blank cyc %0d: got %b want %b", i, {d_hsync, d_blank}, {exp_hs, exp_bl});
            end
            if (i < 1344) tick();
        end
        checks++;
        if ({d_y_hi, d_y_lo} !== 11'd1) begin
            errors++; $display("FAIL line_y_adv: got %h want 001", {d_y_hi, d_y_lo});
        end
        $display("line: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Three small frames: coordinate split and sync/blank against the reference.
    task automatic test_frames();
        logic [21:0] exp_c;
        logic [2:0]  exp_f;
        for (int i = 0; i < 3 * S_HT * S_VT; i++) begin
            exp_c = {6'(sx / 32), 5'(sx % 32), 5'(sy / 48), 6'(sy % 48)};
            exp_f = {!(sx >= S_HA + S_HFP && sx < S_HA + S_HFP + S_HS),
                     !(sy >= S_VA + S_VFP && sy < S_VA + S_VFP + S_VS),
                     (sx >= S_HA) || (sy >= S_VA)};
            checks++;
            if ({s_x_hi, s_x_lo, s_y_hi, s_y_lo} !== exp_c) begin
                errors++; $display("FAIL frame_coord (%0d,%0d): got %h want %h", sx, sy, {s_x_hi, s_x_lo, s_y_hi, s_y_lo}, exp_c);
            end
            checks++;
            if ({s_hsync, s_vsync, s_blank} !== exp_f) begin
                errors++; $display("FAIL frame_sync (%0d,%0d): got %b want %b", sx, sy, {s_hsync, s_vsync, s_blank}, exp_f);
            end
            tick();
        end
        $display("frames: done, checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_interrupt();
        logic exp_split;
`ifdef VGA_SYNC_LINE_IRQ_EN
        exp_split = 1'b1;
`else
        exp_split = 1'b0;
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        run_to(S_HT - 1, S_IRQ - 1);
        checks++;
        if (s_int !== 1'b0) begin errors++; $display("FAIL irq_before_split: got %b want 0", s_int); end
        tick();
        checks++;
        if (s_int !== exp_split) begin errors++; $display("FAIL irq_split_line: got %b want %b", s_int, exp_split); end
        cli = 1'b1; tick(); cli = 1'b0;
        checks++;
        if (s_int !== 1'b0) begin errors++; $display("FAIL irq_cli_split: got %b want 0", s_int); end

        run_to(S_HT - 1, S_VA - 1);
        checks++;
        if (s_int !== 1'b0) begin errors++; $display("FAIL irq_before_vblank: got %b want 0", s_int); end
        tick();
        checks++;
        if (s_int !== 1'b1) begin errors++; $display("FAIL irq_vblank_rise: got %b want 1", s_int); end
        repeat (10) tick();
        checks++;
        if (s_int !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b want 1", s_int); end
        cli = 1'b1; tick(); cli = 1'b0;
        checks++;
        if (s_int !== 1'b0) begin errors++; $display("FAIL irq_cli: got %b want 0", s_int); end
        tick();
        checks++;
        if (s_int !== 1'b0) begin errors++; $display("FAIL irq_stays_clear: got %b want 0", s_int); end

        // Clear anything from the split line, then hit vblank start with cli held.
        run_to(S_HT - 1, S_VA - 2);
        cli = 1'b1; tick(); cli = 1'b0;
        checks++;
        if (s_int !== 1'b0) begin errors++; $display("FAIL irq_pre_clear: got %b want 0", s_int); end
        run_to(S_HT - 1, S_VA - 1);
        cli = 1'b1; tick(); cli = 1'b0;
        checks++;
        if (s_int !== 1'b1) begin errors++; $display("FAIL irq_set_beats_cli: got %b want 1", s_int); end
        run_to(0, 10);
        checks++;
        if (s_int !== 1'b1) begin errors++; $display("FAIL irq_across_frame: got %b want 1", s_int); end
        $display("interrupt: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Reset while hsync/vsync are low and the interrupt is pending.
    task automatic test_reset_mid();
        run_to(46, 53);
        checks++;
        if ({s_hsync, s_vsync, s_blank, s_int} !== 4'b0011) begin
            errors++; $display("FAIL mid_pre_flags: got %b want 0011", {s_hsync, s_vsync, s_blank, s_int});
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({s_x_hi, s_x_lo, s_y_hi, s_y_lo} !== 22'd0) begin
            errors++; $display("FAIL mid_coord: got %h want 0", {s_x_hi, s_x_lo, s_y_hi, s_y_lo});
        end
        checks++;
        if ({s_hsync, s_vsync, s_blank, s_int} !== 4'b1100) begin
            errors++; $display("FAIL mid_flags: got %b want 1100", {s_hsync, s_vsync, s_blank, s_int});
        end
        checks++;
        if ({d_x_hi, d_x_lo, d_y_hi, d_y_lo, d_hsync, d_vsync, d_blank, d_int} !== {22'd0, 4'b1100}) begin
            errors++; $display("FAIL mid_xga: got %h want %h", {d_x_hi, d_x_lo, d_y_hi, d_y_lo, d_hsync, d_vsync, d_blank, d_int}, {22'd0, 4'b1100});
        end
        tick();
        checks++;
        if ({s_x_hi, s_x_lo, s_y_hi, s_y_lo} !== {6'd0, 5'd1, 5'd0, 6'd0}) begin
            errors++; $display("FAIL mid_restart: got %h want x=1", {s_x_hi, s_x_lo, s_y_hi, s_y_lo});
        end
        $display("reset_mid: done, checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_interrupt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
